// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported memory between an instruction-fetch requester (IF)
// and a data-memory requester (DM). Only one access is in flight at a time.
// When both requesters ask together, the one not served last goes first.
// Each access is launched with a one-cycle gnt pulse. It is retired with a
// one-cycle done pulse after the memory answers. If the memory does not answer
// within WAIT_LIMIT wait cycles, the access is retired with err instead.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   if_req, if_addr      fetch request and address (read only)
//   if_gnt, if_done      fetch launch / completion pulses
//   if_rdata             fetch data, valid while if_done=1
//   dm_req, dm_we        data request, 1=store 0=load
//   dm_addr, dm_wdata    data address and store data
//   dm_gnt, dm_done      data launch / completion pulses
//   dm_rdata             load data, valid while dm_done=1
//   mem_re, mem_we       memory read / write strobes (never both high)
//   mem_addr, mem_wdata  memory address / write data, steady while strobed
//   mem_rdata, mem_ready memory read data and completion handshake
//   err                  pulses with done when an access timed out
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_done,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     state;
  logic       last_dm;   // 0: IF was served last, 1: DM was served last
  logic [7:0] wait_cnt;

  // mem_addr / mem_wdata double as the capture registers for the selected
  // request. mem_we remembers whether a DM access is a store until it retires.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      wait_cnt  <= '0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      if_gnt  <= 1'b0;
      dm_gnt  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          // A requester still holds req during its own done cycle. Skipping
          // arbitration in that cycle keeps it from being re-granted for an
          // access it has already finished.
          if (!if_done && !dm_done) begin
            if (dm_req && (!if_req || !last_dm)) begin
              state     <= DM_ACC;
              dm_gnt    <= 1'b1;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_we    <= dm_we;
              mem_re    <= !dm_we;
              wait_cnt  <= '0;
            end else if (if_req) begin
              state    <= IF_ACC;
              if_gnt   <= 1'b1;
              mem_addr <= if_addr;
              mem_re   <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end

        IF_ACC, DM_ACC: begin
          // The access retires on mem_ready. It also retires when the wait
          // count has reached the limit. A ready arriving on the limit cycle
          // still counts as a normal completion.
          if (mem_ready || wait_cnt == LIMIT) begin
            state  <= IDLE;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            err    <= !mem_ready;
            if (state == IF_ACC) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
              last_dm  <= 1'b0;
            end else begin
              dm_done <= 1'b1;
              last_dm <= 1'b1;
              if (!mem_ready) begin
                dm_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32, sets the width of all data buses.
REQ-003 Parameter WAIT_LIMIT, default 15, is the maximum number of cycles to wait for mem_ready before aborting; legal range is 1..255.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port if_req, input, 1 bit: instruction-fetch read request.
REQ-007 Port if_addr, input, ADDR_WIDTH bits: fetch address.
REQ-008 Port if_gnt, output, 1 bit: one-cycle pulse when the fetch access is launched.
REQ-009 Port if_done, output, 1 bit: one-cycle pulse when the fetch access completes.
REQ-010 Port if_rdata, output, DATA_WIDTH bits: fetch read data, valid while if_done=1.
REQ-011 Port dm_req, input, 1 bit: data-memory request.
REQ-012 Port dm_we, input, 1 bit: data access type; 1=store, 0=load.
REQ-013 Port dm_addr, input, ADDR_WIDTH bits: data address.
REQ-014 Port dm_wdata, input, DATA_WIDTH bits: store data.
REQ-015 Port dm_gnt, output, 1 bit: one-cycle pulse when the data access is launched.
REQ-016 Port dm_done, output, 1 bit: one-cycle pulse when the data access completes.
REQ-017 Port dm_rdata, output, DATA_WIDTH bits: load data, valid while dm_done=1.
REQ-018 Port mem_re, output, 1 bit: memory read strobe.
REQ-019 Port mem_we, output, 1 bit: memory write strobe.
REQ-020 Port mem_addr, output, ADDR_WIDTH bits: memory address.
REQ-021 Port mem_wdata, output, DATA_WIDTH bits: memory write data.
REQ-022 Port mem_rdata, input, DATA_WIDTH bits: memory read data.
REQ-023 Port mem_ready, input, 1 bit: memory access complete, sampled only while a strobe is high.
REQ-024 Port err, output, 1 bit: one-cycle pulse, coincident with the done pulse, marking an aborted (timed-out) access.

Function
REQ-025 All outputs SHALL be registered.
REQ-026 The FSM SHALL have states IDLE, IF_ACC and DM_ACC.
REQ-027 In IDLE with exactly one request pending, that requester SHALL be selected.
REQ-028 In IDLE with both requests pending, the requester not served last SHALL be selected; the last-served register resets to IF, so DM wins the first tie.
REQ-029 When a request is selected in IDLE at cycle N, in cycle N+1 the state SHALL be IF_ACC or DM_ACC, the matching gnt SHALL be high for that cycle only, and the strobes SHALL be driven from the captured address/data.
REQ-030 Strobe selection: IF access drives mem_re=1; DM load drives mem_re=1; DM store drives mem_we=1.
REQ-031 mem_re and mem_we SHALL never both be high.
REQ-032 Address, write data and access type SHALL be latched at selection; the requester holds req until done, and input changes after selection SHALL be ignored.
REQ-033 Strobes, mem_addr and mem_wdata SHALL hold steady until the cycle in which mem_ready=1 is sampled.
REQ-034 When mem_ready=1 is sampled in an ACC state: in the following cycle the matching done SHALL pulse, rdata SHALL carry the captured mem_rdata (loads and fetches; unchanged for stores), the strobes SHALL be low, and the state SHALL be IDLE.
REQ-035 Minimum latency is 2 cycles from strobe assertion to done; back-to-back accesses SHALL be separated by at least one IDLE cycle.
REQ-036 A wait counter (8 bits) SHALL clear on entry to an ACC state and increment on each cycle with mem_ready=0.
REQ-037 When the wait count reaches WAIT_LIMIT with mem_ready still 0, the access SHALL abort: next cycle done and err pulse together, rdata=0, strobes low, state IDLE.
REQ-038 If mem_ready=1 arrives in the same cycle the limit is reached, it SHALL complete normally with err=0.
REQ-039 mem_ready while in IDLE SHALL be ignored.
REQ-040 A done pulse updates the last-served register to the completing requester, including aborted accesses.

Reset
REQ-041 When reset=1 at a rising edge, the next state SHALL be IDLE and the following SHALL be 0: all outputs, the wait counter, and the captured address/data.
REQ-042 Last-served SHALL reset to IF.
REQ-043 Reset during an ACC state SHALL abandon the access with no done or err pulse.
REQ-044 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-045 IF-only read: if_req=1, if_addr=0x40, mem_ready=1 in the first strobe cycle, mem_rdata=0x00500093 -> if_gnt at N+1, if_done at N+2 with if_rdata=0x00500093, err=0.
REQ-046 DM store with 3 wait cycles: dm_we=1, addr=0x100, wdata=0xDEADBEEF -> mem_we high for exactly 4 cycles with steady addr/data, dm_done one cycle later, mem_re never high.
REQ-047 Simultaneous requests held for 3 accesses -> grant order DM, IF, DM, each separated by at least one IDLE cycle.
REQ-048 Timeout: WAIT_LIMIT=4, mem_ready held 0 -> strobe high for 5 cycles, then dm_done=1, err=1, dm_rdata=0, state IDLE.
REQ-049 Reset asserted in the second wait cycle of an IF access -> strobes low after that edge, no if_done, and an IF request is granted normally after reset is released.
REQ-050 mem_ready coincident with the limit cycle -> normal completion, err=0, rdata equal to mem_rdata.
